// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared constants and opcode helpers for the dual-issue dispatch stage
// Purpose: opcodes, tag bases, CDB/dispatch bus layout, idle tag and
// opcode classification helpers used by multi_issue_dispatch and rs_free_pool.
package dispatch_pkg;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_MULT  = 8'h04;

  localparam logic [7:0] REG_BASE = 8'h10;
  localparam logic [7:0] ADD_BASE = 8'h20;
  localparam logic [7:0] MUL_BASE = 8'h30;
  localparam logic [7:0] LD_BASE  = 8'h40;
  localparam logic [7:0] ST_BASE  = 8'h50;

  localparam logic [7:0] TAG_IDLE = 8'h00;

  localparam int TAG_W    = 8;
  localparam int DATA_W   = 32;
  localparam int BUS_W    = TAG_W + DATA_W;
  localparam int TAG_LSB  = DATA_W;
  localparam int DATA_LSB = 0;
  localparam int INST_W   = 32;

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_MUL = 2'd1,
    CLS_LD  = 2'd2,
    CLS_ST  = 2'd3
  } rs_class_e;

  function automatic logic op_valid(input logic [7:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_MULT);
  endfunction

  // Classes for bubbles are don't-care; callers gate with op_valid.
  function automatic rs_class_e op_class(input logic [7:0] op);
    case (op)
      OP_MULT:  return CLS_MUL;
      OP_LOAD:  return CLS_LD;
      OP_STORE: return CLS_ST;
      default:  return CLS_ADD;
    endcase
  endfunction

  // Ops that produce a register result and therefore claim RST[f1].
  function automatic logic op_writes(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MULT) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/rs_free_pool.sv
// rtl/rs_free_pool.sv - free bitmap for one reservation-station class
// Purpose: tracks busy entries of one class, offers the two lowest free tags,
// allocates 0/1/2 of them per cycle and releases entries named on rel.
// Ports:
//   clk, rst       clock, synchronous active-high reset (all entries free)
//   take[1:0]      number of entries allocated this cycle (lowest first)
//   rel[31:0]      four release tags {add, mult, load, store}; 0 is idle
//   has1, tag_lo   at least one free entry, and the lowest free tag
//   has2, tag_hi   at least two free entries, and the second lowest tag
module rs_free_pool
  import dispatch_pkg::*;
#(
  parameter int              N    = 2,
  parameter logic [TAG_W-1:0] BASE = ADD_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         take,
  input  logic [4*TAG_W-1:0] rel,
  output logic               has1,
  output logic               has2,
  output logic [TAG_W-1:0]   tag_lo,
  output logic [TAG_W-1:0]   tag_hi
);

  logic [N-1:0] busy;
  logic [N-1:0] grab;
  logic [N-1:0] rel_hit;

  always_comb begin
    has1   = 1'b0;
    has2   = 1'b0;
    tag_lo = TAG_IDLE;
    tag_hi = TAG_IDLE;
    grab   = '0;
    for (int i = 0; i < N; i++) begin
      if (!busy[i]) begin
        if (!has1) begin
          has1    = 1'b1;
          tag_lo  = BASE + TAG_W'(i);
          grab[i] = (take != 2'd0);
        end else if (!has2) begin
          has2    = 1'b1;
          tag_hi  = BASE + TAG_W'(i);
          grab[i] = (take == 2'd2);
        end
      end
    end
  end

  // Bases start at 8'h20, so an idle (zero) release tag never matches.
  always_comb begin
    rel_hit = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (rel[k*TAG_W +: TAG_W] == BASE + TAG_W'(i)) rel_hit[i] = 1'b1;
      end
    end
  end

  // Allocation only looks at the registered bitmap, so a released entry
  // becomes allocatable one cycle after its release.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~rel_hit) | grab;
  end

endmodule

// File: rtl/multi_issue_dispatch.sv
// rtl/multi_issue_dispatch.sv - two-wide in-order dispatch with register renaming
// Purpose: accepts two program-order instructions per cycle, allocates
// reservation-station tags, renames sources through the register status
// table (RST) and emits registered dispatch words.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   inst1, inst2 [31:0]         {op, f1, f2, f3}; slot1 is older
//   addbus, multbus, loadbus    CDB {tag, data}; tag 0 idle
//   storesig [7:0]              store completion tag; 0 idle
//   instbus1, instbus2 [39:0]   registered {tag, op, f1', f2', f3'}; 0 = none
//   stall1, stall2              combinational: slot not accepted this cycle
// Configuration: define DISPATCH_CDB_BYPASS_EN to emit a source whose RST tag
// is broadcast on the CDB in the same cycle as its register ID.
module multi_issue_dispatch
  import dispatch_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int N_ADD    = 3,
  parameter int N_MUL    = 2,
  parameter int N_LD     = 2,
  parameter int N_ST     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst1,
  input  logic [INST_W-1:0] inst2,
  input  logic [BUS_W-1:0]  addbus,
  input  logic [BUS_W-1:0]  multbus,
  input  logic [BUS_W-1:0]  loadbus,
  input  logic [TAG_W-1:0]  storesig,
  output logic [BUS_W-1:0]  instbus1,
  output logic [BUS_W-1:0]  instbus2,
  output logic              stall1,
  output logic              stall2
);

  logic [7:0] op1, f11, f12, f13;
  logic [7:0] op2, f21, f22, f23;
  assign {op1, f11, f12, f13} = inst1;
  assign {op2, f21, f22, f23} = inst2;

  logic [TAG_W-1:0] add_tag, mul_tag, ld_tag;
  assign add_tag = addbus[TAG_LSB +: TAG_W];
  assign mul_tag = multbus[TAG_LSB +: TAG_W];
  assign ld_tag  = loadbus[TAG_LSB +: TAG_W];

  logic unused_data;
  assign unused_data = ^{addbus[DATA_LSB +: DATA_W], multbus[DATA_LSB +: DATA_W],
                         loadbus[DATA_LSB +: DATA_W]};

  logic [TAG_W-1:0] rst_tab [NUM_REGS];

  logic [3:0]       has1, has2;
  logic [TAG_W-1:0] tag_lo [4];
  logic [TAG_W-1:0] tag_hi [4];
  logic [1:0]       take   [4];
  logic [4*TAG_W-1:0] rel_tags;
  assign rel_tags = {add_tag, mul_tag, ld_tag, storesig};

  logic      v1, v2, same_cls, acc1, acc2, wr1, wr2;
  rs_class_e c1, c2;
  logic [TAG_W-1:0] t1, t2;
  logic [3:0] sel1, sel2;
  logic [23:0] fld1, fld2;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] t);
    return (t != TAG_IDLE) && ((t == add_tag) || (t == mul_tag) || (t == ld_tag));
  endfunction

  // Out-of-range fields fall through the loop unchanged.
  function automatic logic [7:0] rename(input logic [7:0] f);
    logic [7:0] r;
    r = f;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (f == REG_BASE + TAG_W'(i) && rst_tab[i] != TAG_IDLE) begin
`ifdef DISPATCH_CDB_BYPASS_EN
        if (!cdb_hit(rst_tab[i])) r = rst_tab[i];
`else
        r = rst_tab[i];
`endif
      end
    end
    return r;
  endfunction

  // Slot2 sources that name slot1's destination take slot1's fresh tag,
  // since slot1's RST write is not visible until the next edge.
  function automatic logic [7:0] src(input logic [7:0] f, input logic fwd_en,
                                     input logic [7:0] fwd_reg, input logic [7:0] fwd_tag);
    if (fwd_en && f == fwd_reg) return fwd_tag;
    return rename(f);
  endfunction

  function automatic logic [23:0] map_fields(input logic [7:0] op, input logic [7:0] f1,
                                             input logic [7:0] f2, input logic [7:0] f3,
                                             input logic fwd_en, input logic [7:0] fwd_reg,
                                             input logic [7:0] fwd_tag);
    case (op)
      OP_ADD, OP_MULT: return {f1, src(f2, fwd_en, fwd_reg, fwd_tag), src(f3, fwd_en, fwd_reg, fwd_tag)};
      OP_STORE:        return {src(f1, fwd_en, fwd_reg, fwd_tag), f2, f3};
      default:         return {f1, f2, f3};
    endcase
  endfunction

  always_comb begin
    v1       = op_valid(op1);
    v2       = op_valid(op2);
    c1       = op_class(op1);
    c2       = op_class(op2);
    same_cls = v1 && v2 && (c1 == c2);
    stall1   = !rst && v1 && !has1[c1];
    // In-order issue: a stalled slot1 holds slot2 as well.
    stall2   = !rst && (stall1 || (v2 && (same_cls ? !has2[c2] : !has1[c2])));
    acc1     = !rst && v1 && !stall1;
    acc2     = !rst && v2 && !stall2;
    wr1      = acc1 && op_writes(op1);
    wr2      = acc2 && op_writes(op2);
    t1       = tag_lo[c1];
    t2       = same_cls ? tag_hi[c2] : tag_lo[c2];
    sel1     = acc1 ? (4'b0001 << c1) : 4'b0000;
    sel2     = acc2 ? (4'b0001 << c2) : 4'b0000;
    for (int k = 0; k < 4; k++) take[k] = {1'b0, sel1[k]} + {1'b0, sel2[k]};
    fld1     = map_fields(op1, f11, f12, f13, 1'b0, f11, t1);
    fld2     = map_fields(op2, f21, f22, f23, wr1, f11, t1);
  end

  rs_free_pool #(.N(N_ADD), .BASE(ADD_BASE)) u_add_pool (
    .clk(clk), .rst(rst), .take(take[CLS_ADD]), .rel(rel_tags),
    .has1(has1[CLS_ADD]), .has2(has2[CLS_ADD]), .tag_lo(tag_lo[CLS_ADD]), .tag_hi(tag_hi[CLS_ADD])
  );

  rs_free_pool #(.N(N_MUL), .BASE(MUL_BASE)) u_mul_pool (
    .clk(clk), .rst(rst), .take(take[CLS_MUL]), .rel(rel_tags),
    .has1(has1[CLS_MUL]), .has2(has2[CLS_MUL]), .tag_lo(tag_lo[CLS_MUL]), .tag_hi(tag_hi[CLS_MUL])
  );

  rs_free_pool #(.N(N_LD), .BASE(LD_BASE)) u_ld_pool (
    .clk(clk), .rst(rst), .take(take[CLS_LD]), .rel(rel_tags),
    .has1(has1[CLS_LD]), .has2(has2[CLS_LD]), .tag_lo(tag_lo[CLS_LD]), .tag_hi(tag_hi[CLS_LD])
  );

  rs_free_pool #(.N(N_ST), .BASE(ST_BASE)) u_st_pool (
    .clk(clk), .rst(rst), .take(take[CLS_ST]), .rel(rel_tags),
    .has1(has1[CLS_ST]), .has2(has2[CLS_ST]), .tag_lo(tag_lo[CLS_ST]), .tag_hi(tag_hi[CLS_ST])
  );

  // RST priority per register: slot2 write, slot1 write, CDB clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) rst_tab[r] <= TAG_IDLE;
      instbus1 <= '0;
      instbus2 <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr2 && f21 == REG_BASE + TAG_W'(r))      rst_tab[r] <= t2;
        else if (wr1 && f11 == REG_BASE + TAG_W'(r)) rst_tab[r] <= t1;
        else if (cdb_hit(rst_tab[r]))                rst_tab[r] <= TAG_IDLE;
      end
      instbus1 <= acc1 ? {t1, op1, fld1} : '0;
      instbus2 <= acc2 ? {t2, op2, fld2} : '0;
    end
  end

endmodule

// File: doc/multi_issue_dispatch.md
MULTI_ISSUE_DISPATCH -- requirements
Module: multi_issue_dispatch

Interface
REQ-001 Parameters, one per line: name, default, meaning. NUM_REGS, 4, architectural registers (1..16), IDs 8'h10+r.
REQ-002 N_ADD, 3, adder RS entries (1..16), tags 8'h20+i; N_MUL, 2, multiplier RS entries, tags 8'h30+i.
REQ-003 N_LD, 2, load buffer entries, tags 8'h40+i; N_ST, 2, store buffer entries, tags 8'h50+i.
REQ-004 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
REQ-005 clk  in  1  single clock, rising edge; all state updates on this edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 inst1, inst2  in  32  program-order slots {op[31:24], f1[23:16], f2[15:8], f3[7:0]}; op 01 LOAD, 02 STORE, 03 ADD, 04 MULTI; any other op is a bubble.
REQ-008 addbus, multbus, loadbus  in  40  CDB {tag[39:32], data[31:0]}; tag 0 means idle.
REQ-009 storesig  in  8  store-completion tag; 0 means idle.
REQ-010 instbus1, instbus2  out  40  registered dispatch word {rs_tag, op, f1', f2', f3'}; all zero means no dispatch.
REQ-011 stall1, stall2  out  1  combinational: the slot is not accepted this cycle, and upstream holds it.

Function
REQ-012 Rename rules: ADD/MULTI give f1'=f1 and rename f2 and f3; LOAD gives f1'=f1, f2'=f2, f3'=f3; STORE renames f1, f2'=f2, f3'=f3.
REQ-013 Renaming a register returns the register-status tag (RST[r]) if it is nonzero, otherwise the register ID itself.
REQ-014 Slot2 reads slot1's allocated tag for any source equal to slot1's f1 when slot1 is ADD, MULTI or LOAD and dispatches in the same cycle.
REQ-015 Allocation takes the lowest-index free entry of the class; two same-class slots take the lowest two; slot1 has priority.
REQ-016 stall1 asserts when no entry of its class is free; stall2 asserts when stall1 asserts or its class has no entry left.
REQ-017 The bus output appears one cycle after acceptance; a stalled or bubble slot drives zero on its bus.
REQ-018 On acceptance of ADD, MULTI or LOAD, RST[f1] is set to the allocated tag; when both slots write the same register, slot2's tag wins.
REQ-019 A CDB tag or storesig frees the matching entry at the edge; the freed entry is allocatable from the next cycle.
REQ-020 A CDB tag clears every RST[r] equal to it, unless a same-cycle dispatch writes r, in which case the dispatch wins.
REQ-021 A register field outside 8'h10..8'h10+NUM_REGS-1 is passed through unrenamed and does not update the RST.
REQ-022 Multiple simultaneous CDB tags are all processed in the same cycle.

Reset
REQ-023 When rst is high at the clock edge: all RS entries become free, all RST entries become 0, and instbus1 and instbus2 become 0.
REQ-024 While rst is high, stall1 and stall2 are 0 and no instruction is accepted; a reset during dispatch discards it.

Configuration
REQ-025 Macro DISPATCH_CDB_BYPASS_EN.
REQ-026 With DISPATCH_CDB_BYPASS_EN defined, a source whose RST tag matches a same-cycle CDB tag is emitted as the register ID.
REQ-027 Without DISPATCH_CDB_BYPASS_EN, that source is emitted as the tag and becomes ready from the next cycle.

Structure
REQ-028 Shared package dispatch_pkg holds: opcode constants, tag bases 8'h10/20/30/40/50, the 40-bit bus field widths and offsets, and the idle-tag constant 0.
REQ-029 One sub-module, rs_free_pool (parameters N and BASE), provides the free bitmap, lowest-two allocation and release.
REQ-030 multi_issue_dispatch instantiates four rs_free_pool instances and holds the RST and renaming logic.

Verification
REQ-031 Apply rst, then inst1=01110000 (LOAD R1) and inst2=04111112 (MULTI R1,R1,R2) -> next cycle instbus1=40_01_11_00_00 and instbus2=30_04_11_40_12; RST[R1]=30.
REQ-032 Issue 4 ADDs over 2 cycles with N_ADD=3 -> tags 20, 21, 22; the 4th ADD gets stall asserted; addbus={21,x} -> the 4th ADD dispatches with tag 21 the cycle after.
REQ-033 ADD R3,R1,R2 pending with RST[R1]=40, then loadbus={40,data} -> RST[R1]=0; a later reader of R1 receives 11.
REQ-034 With DISPATCH_CDB_BYPASS_EN, a reader of R1 dispatched in the same cycle as loadbus tag 40 -> field 11; without the macro -> field 40.
REQ-035 inst1 stalls (no free MUL) and inst2 is an ADD -> stall2=1 and instbus2=0 (in-order issue).
REQ-036 Assert rst for 1 cycle with all entries busy -> all outputs 0; the next ADD receives tag 20 and all sources read as register IDs.
